// File: rtl/motion_pkg.sv
// Shared constants, FSM state type and frame-size clamp helper
// for the motion mask generator.
package motion_pkg;

    localparam int MAX_WIDTH_DEF  = 1280;
    localparam int MAX_HEIGHT_DEF = 720;

    localparam logic [7:0]  MASK_ON  = 8'hFF;
    localparam logic [7:0]  MASK_OFF = 8'h00;
    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Zero is treated as one; oversize values clamp to the maximum.
    function automatic logic [10:0] clamp_dim(
        input logic [10:0] v,
        input logic [10:0] mx
    );
        if (v == 11'd0)
            return 11'd1;
        else if (v > mx)
            return mx;
        else
            return v;
    endfunction

endpackage

// File: rtl/motion_mask_gen_abs_diff8.sv
// Unsigned 8-bit absolute difference, combinational, no wraparound.
module abs_diff8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_d
);

    assign o_d = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);

endmodule

// File: rtl/motion_mask_gen.sv
// Three-frame differencing motion mask with AXI-Stream style output,
// frame position tracking and per-frame motion pixel count.
module motion_mask_gen
    import motion_pkg::*;
#(
    parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
    parameter int MAX_HEIGHT = MAX_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  curr_pixel,
    input  logic [7:0]  pixel_t1,
    input  logic [7:0]  pixel_t2,
    input  logic        in_last,
    input  logic [10:0] width,
    input  logic [9:0]  height,
    input  logic [7:0]  threshold,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_user,
    output logic        out_last,
    output logic [19:0] motion_count,
    output logic        frame_done
);

    state_t r_state;
    state_t w_next;

    logic w_act;
    logic w_stall;
    logic w_adv;
    logic w_acc;
    logic w_eof;
    logic w_col_end;
    logic w_row_end;
    logic w_hit;

    logic       r_s1_valid;
    logic [7:0] r_s1_curr;
    logic [7:0] r_s1_t1;
    logic [7:0] r_s1_t2;
    logic       r_s1_last;

    logic       r_s2_valid;
    logic [7:0] r_s2_d1;
    logic [7:0] r_s2_d2;
    logic       r_s2_last;

    logic       r_s3_valid;
    logic [7:0] r_s3_data;
    logic       r_s3_last;

    logic [7:0] w_d1;
    logic [7:0] w_d2;

    logic [10:0] r_col;
    logic [9:0]  r_row;
    logic [10:0] r_sh_w;
    logic [9:0]  r_sh_h;
    logic [10:0] w_w_clamp;
    logic [9:0]  w_h_clamp;

    logic [19:0] r_acc;
    logic [19:0] w_acc_next;
    logic [19:0] r_count;
    logic        r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (enable)  w_next = RUN;
            RUN:  if (!enable) w_next = IDLE;
        endcase
    end

    always_comb begin
        w_act = 1'b0;
        unique case (r_state)
            IDLE: w_act = 1'b0;
            RUN:  w_act = enable;
        endcase
    end

    // The output beat is hidden while idle so it is never accepted twice.
    assign out_valid = r_s3_valid && w_act;
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = w_act && !w_stall;
    assign w_adv     = in_ready;
    assign w_acc     = out_valid && out_ready;

    abs_diff8 u_diff_t1 (
        .i_a (r_s1_curr),
        .i_b (r_s1_t1),
        .o_d (w_d1)
    );

    abs_diff8 u_diff_t2 (
        .i_a (r_s1_curr),
        .i_b (r_s1_t2),
        .o_d (w_d2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_curr  <= 8'd0;
            r_s1_t1    <= 8'd0;
            r_s1_t2    <= 8'd0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_d1    <= 8'd0;
            r_s2_d2    <= 8'd0;
            r_s2_last  <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_data  <= MASK_OFF;
            r_s3_last  <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_curr  <= curr_pixel;
            r_s1_t1    <= pixel_t1;
            r_s1_t2    <= pixel_t2;
            r_s1_last  <= in_valid && in_last;
            r_s2_valid <= r_s1_valid;
            r_s2_d1    <= w_d1;
            r_s2_d2    <= w_d2;
            r_s2_last  <= r_s1_last;
            r_s3_valid <= r_s2_valid;
            r_s3_data  <= (r_s2_valid &&
                           (r_s2_d1 > threshold) &&
                           (r_s2_d2 > threshold)) ? MASK_ON : MASK_OFF;
            r_s3_last  <= r_s2_last;
        end
    end

    assign w_w_clamp = clamp_dim(width, 11'(MAX_WIDTH));
    assign w_h_clamp = 10'(clamp_dim({1'b0, height}, 11'(MAX_HEIGHT)));

    assign w_col_end = (r_col == r_sh_w - 11'd1);
    assign w_row_end = (r_row == r_sh_h - 10'd1);
    assign w_eof     = w_acc && ((w_col_end && w_row_end) || r_s3_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_w <= 11'd1;
            r_sh_h <= 10'd1;
            r_col  <= 11'd0;
            r_row  <= 10'd0;
        end else begin
            if (r_state == IDLE || w_eof) begin
                r_sh_w <= w_w_clamp;
                r_sh_h <= w_h_clamp;
            end
            if (w_eof) begin
                r_col <= 11'd0;
                r_row <= 10'd0;
            end else if (w_acc) begin
                if (w_col_end) begin
                    r_col <= 11'd0;
                    r_row <= r_row + 10'd1;
                end else begin
                    r_col <= r_col + 11'd1;
                end
            end
        end
    end

    assign w_hit      = (r_s3_data == MASK_ON);
    assign w_acc_next = (!w_hit || r_acc == CNT_MAX) ? r_acc : r_acc + 20'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= 20'd0;
            r_count <= 20'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_eof;
            if (w_eof) begin
                r_count <= w_acc_next;
                r_acc   <= 20'd0;
            end else if (w_acc) begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign out_data     = r_s3_data;
    assign out_user     = out_valid && (r_col == 11'd0) && (r_row == 10'd0);
    assign out_last     = out_valid && w_col_end;
    assign motion_count = r_count;
    assign frame_done   = r_done;

endmodule
